// File: rtl/uart_frame_parser.sv
// Frame parser for a UART byte stream: SYNC, LEN, payload, XOR checksum.
// Buffers one frame and replays the validated payload over valid/ready.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  frame_data,
  output logic        frame_data_valid,
  input  logic        frame_data_ready,
  output logic        frame_last,
  output logic        busy,
  output logic        err_checksum,
  output logic        err_length,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic [15:0] frame_count
);

  localparam int unsigned IdxW = $clog2(MAX_LEN + 1);
  localparam int unsigned BufW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);
  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxOne = IdxW'(1);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StOut} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] len_q, len_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      acc_q, acc_d;
  logic [31:0]     tmo_q, tmo_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_tmo_q, err_tmo_d;
  logic            err_ovr_q, err_ovr_d;
  logic            buf_we;
  logic            at_last;
  logic            in_frame;
  logic [7:0]      buf_q [MAX_LEN];

  assign at_last  = (idx_q == len_q - IdxOne);
  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      cnt_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  // Payload storage needs no reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[BufW-1:0]] <= rx_byte;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    buf_we    = 1'b0;

    // Silence inside a frame counts toward the timeout; any byte restarts it.
    if (in_frame && !rx_byte_valid) begin
      if (tmo_q == TmoLast) begin
        err_tmo_d = 1'b1;
        state_d   = StIdle;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (rx_byte_valid && rx_byte == SYNC_BYTE) begin
          state_d = StLen;
          tmo_d   = '0;
        end
      end
      StLen: begin
        if (rx_byte_valid) begin
          tmo_d = '0;
          if (rx_byte != 8'h00 && rx_byte <= MaxLenB) begin
            len_d   = rx_byte[IdxW-1:0];
            idx_d   = '0;
            acc_d   = rx_byte;
            state_d = StPayload;
          end else begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StPayload: begin
        if (rx_byte_valid) begin
          tmo_d  = '0;
          buf_we = 1'b1;
          acc_d  = acc_q ^ rx_byte;
          idx_d  = idx_q + IdxOne;
          if (at_last) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (rx_byte_valid) begin
          tmo_d = '0;
          if (rx_byte == acc_q) begin
            cnt_d   = cnt_q + 16'd1;
            idx_d   = '0;
            state_d = StOut;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StOut: begin
        err_ovr_d = rx_byte_valid;
        if (frame_data_ready) begin
          if (at_last) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frame_data_valid = (state_q == StOut);
    frame_data       = frame_data_valid ? buf_q[idx_q[BufW-1:0]] : 8'h00;
    frame_last       = frame_data_valid && at_last;
    busy             = (state_q != StIdle);
    err_checksum     = err_chk_q;
    err_length       = err_len_q;
    err_timeout      = err_tmo_q;
    err_overrun      = err_ovr_q;
    frame_count      = cnt_q;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a queue scoreboard and a
// negedge monitor that checks every presented payload byte.
module tb_uart_frame_parser;

  localparam int unsigned Tmo = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  frame_data;
  logic        frame_data_valid;
  logic        frame_data_ready;
  logic        frame_last;
  logic        busy;
  logic        err_checksum;
  logic        err_length;
  logic        err_timeout;
  logic        err_overrun;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_chk = 0;
  int n_len = 0;
  int n_tmo = 0;
  int n_ovr = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_frame_parser #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_byte          (rx_byte),
    .rx_byte_valid    (rx_byte_valid),
    .frame_data       (frame_data),
    .frame_data_valid (frame_data_valid),
    .frame_data_ready (frame_data_ready),
    .frame_last       (frame_last),
    .busy             (busy),
    .err_checksum     (err_checksum),
    .err_length       (err_length),
    .err_timeout      (err_timeout),
    .err_overrun      (err_overrun),
    .frame_count      (frame_count)
  );

  // Monitor: compares the head of the scoreboard while valid, pops on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_checksum) n_chk++;
      if (err_length)   n_len++;
      if (err_timeout)  n_tmo++;
      if (err_overrun)  n_ovr++;
      if (frame_data_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: got data=%02h last=%0b, required no output",
                   frame_data, frame_last);
        end else begin
          if ({frame_last, frame_data} !== exp_q[0]) begin
            n_bad++;
            $display("FAIL payload: got data=%02h last=%0b, required data=%02h last=%0b",
                     frame_data, frame_last, exp_q[0][7:0], exp_q[0][8]);
          end
          if (frame_data_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_byte_valid = 1'b0;
    rx_byte       = 8'h00;
  endtask

  task automatic push(input logic [7:0] b, input logic last);
    exp_q.push_back({last, b});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !frame_data_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    check({name, "_valid_low"}, frame_data_valid, 1'b0);
  endtask

  task automatic check_errs(input string name, input int c, input int l, input int t,
                            input int o);
    check({name, "_err_checksum"}, n_chk, c);
    check({name, "_err_length"},   n_len, l);
    check({name, "_err_timeout"},  n_tmo, t);
    check({name, "_err_overrun"},  n_ovr, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    rx_byte          = 8'h00;
    rx_byte_valid    = 1'b0;
    frame_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", frame_data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", frame_count, 0);
    check("rst_data", frame_data, 0);
    check("rst_last", frame_last, 0);
    check("rst_errs", {err_checksum, err_length, err_timeout, err_overrun}, 0);

    // Good frame preceded by garbage, ready held high
    @(posedge clk); #1;
    send(8'h00); send(8'hFF);
    @(negedge clk);
    check("garbage_busy", busy, 0);
    @(posedge clk); #1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    send(8'h03);
    wait_drain("good");
    check("good_count", frame_count, 1);
    check_errs("good", 0, 0, 0, 0);

    // Backpressure: 5 stalled cycles then ready toggles
    frame_data_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    send(8'h03);
    repeat (5) begin @(posedge clk); #1; end
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !frame_data_valid) break;
      frame_data_ready = ~frame_data_ready;
      @(posedge clk); #1;
    end
    frame_data_ready = 1'b1;
    wait_drain("bp");
    check("bp_count", frame_count, 2);

    // Bad checksum, then a good one-byte frame
    send(8'hA5); send(8'h02); send(8'hAA); send(8'h55); send(8'h00);
    @(negedge clk);
    check("badchk_busy", busy, 0);
    check("badchk_count", frame_count, 2);
    @(posedge clk); #1;
    send(8'hA5); send(8'h01); send(8'h7E);
    push(8'h7E, 1);
    send(8'h7F);
    wait_drain("after_bad");
    check("after_bad_count", frame_count, 3);
    check_errs("badchk", 1, 0, 0, 0);

    // Length errors: zero and MAX_LEN+1
    send(8'hA5); send(8'h00);
    @(negedge clk);
    check("len0_busy", busy, 0);
    @(posedge clk); #1;
    send(8'hA5); send(8'h11);
    @(negedge clk);
    check("len17_busy", busy, 0);
    @(posedge clk); #1;
    check_errs("len", 1, 2, 0, 0);

    // Timeout in PAYLOAD: still busy on the last allowed cycle, then aborted
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (Tmo - 1) @(posedge clk);
    #1;
    check("tmo_busy_before", busy, 1);
    check("tmo_none_before", n_tmo, 0);
    repeat (3) @(posedge clk);
    #1;
    check("tmo_busy_after", busy, 0);
    check_errs("tmo", 1, 2, 1, 0);

    // A byte arriving on the expiry cycle wins over the timeout
    send(8'hA5);
    repeat (Tmo - 1) @(posedge clk);
    #1;
    send(8'h01); send(8'h5A);
    push(8'h5A, 1);
    send(8'h5B);
    wait_drain("edge_byte");
    check("edge_count", frame_count, 4);
    check_errs("edge", 1, 2, 1, 0);

    // Reset during PAYLOAD
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_valid", frame_data_valid, 0);
    check("midrst_count", frame_count, 0);
    @(posedge clk); #1;
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20);
    push(8'h10, 0); push(8'h20, 1);
    send(8'h32);
    wait_drain("post_rst");
    check("post_rst_count", frame_count, 1);

    // Overrun: three bytes while OUT is stalled
    frame_data_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'hC1); send(8'hC2); send(8'hC3);
    push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 1);
    send(8'hC3);
    send(8'hA5); send(8'h11); send(8'h22);
    @(posedge clk); #1;
    check("ovr_busy", busy, 1);
    frame_data_ready = 1'b1;
    wait_drain("ovr");
    check("ovr_count", frame_count, 2);
    check_errs("ovr", 1, 2, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
